// File: rtl/param_fir_filter_if.sv
// Sample, coefficient-config and status bundle of param_fir_filter.
// The slave modport is the filter and the master modport is the driving block.
interface param_fir_filter_if #(
    parameter int IN_W   = 18,
    parameter int COEF_W = 25,
    parameter int OUT_W  = 8,
    parameter int NTAPS  = 21,
    parameter int LEN_W  = $clog2(NTAPS + 1)
);
    // Handshake: valid_in and cfg_ce are single-cycle qualifiers that take effect on
    // the rising clk edge where they are high. They are consumed only while in_ready
    // and cfg_ready are high. A valid_in seen while in_ready is low is dropped and
    // flagged on overrun. A cfg_ce seen while cfg_ready is low is ignored silently.
    // valid_out is a one-cycle strobe with no back-pressure.
    logic signed [IN_W-1:0]   in;
    logic                     valid_in;
    logic                     in_ready;
    logic signed [OUT_W-1:0]  out;
    logic                     valid_out;
    logic signed [COEF_W-1:0] cfg_din;
    logic                     cfg_ce;
    logic                     cfg_ready;
    logic [LEN_W-1:0]         len;
    logic                     overrun;
    logic                     clear_ovr;
    logic [1:0]               dbg_state;

    modport master (
        output in, valid_in, cfg_din, cfg_ce, clear_ovr,
        input  in_ready, out, valid_out, cfg_ready, len, overrun, dbg_state
    );

    modport slave (
        input  in, valid_in, cfg_din, cfg_ce, clear_ovr,
        output in_ready, out, valid_out, cfg_ready, len, overrun, dbg_state
    );
endinterface

// File: rtl/param_fir_filter.sv
// Time-multiplexed single-MAC FIR filter with shift-loaded coefficients and rounded output scaling.
// Define FIR_SAT_EN to clamp the scaled result to the output range instead of wrapping it.
module param_fir_filter #(
    parameter int IN_W      = 18,
    parameter int COEF_W    = 25,
    parameter int OUT_W     = 8,
    parameter int NTAPS     = 21,
    parameter int ACC_W     = 48,
    parameter int OUT_SHIFT = 29
) (
    input logic clk,
    input logic reset,
    param_fir_filter_if.slave bus
);
    localparam int PTR_W  = $clog2(NTAPS);
    localparam int LEN_W  = $clog2(NTAPS + 1);
    localparam int PROD_W = IN_W + COEF_W;

    localparam logic [PTR_W-1:0]       P_LAST  = PTR_W'(NTAPS - 1);
    localparam logic [LEN_W-1:0]       LEN_MAX = LEN_W'(NTAPS);
    localparam logic signed [ACC_W:0]  ONE_W   = {{ACC_W{1'b0}}, 1'b1};
    localparam logic signed [ACC_W:0]  RND     = ONE_W <<< (OUT_SHIFT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic signed [COEF_W-1:0] coef_q [NTAPS];
    logic signed [IN_W-1:0]   buf_q  [NTAPS];
    logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q, k_q;
    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [OUT_W-1:0]  out_q, scaled;
    logic                     valid_out_q, overrun_q;
    logic [LEN_W-1:0]         len_q;
    logic                     idle, accept, cfg_wr, drop;
    logic signed [ACC_W:0]    sum, r_full;

    assign idle   = (state_q == S_IDLE);
    assign accept = idle && bus.valid_in;
    assign cfg_wr = idle && bus.cfg_ce;
    assign drop   = !idle && bus.valid_in;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.valid_in) state_d = S_MAC;
            S_MAC:   if (k_q == P_LAST) state_d = S_DRAIN;
            S_DRAIN: state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // rd_ptr walks backwards from the newest sample, so tap k sees x[n-k].
    assign prod_d = PROD_W'(coef_q[k_q]) * PROD_W'(buf_q[rd_ptr_q]);

    // Round half up, then arithmetic shift; one guard bit keeps the rounding add from overflowing.
    assign sum    = $signed({acc_q[ACC_W-1], acc_q}) + RND;
    assign r_full = sum >>> OUT_SHIFT;

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W:0] MAXV = {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV = {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

    always_comb begin
        scaled = r_full[OUT_W-1:0];
        if (r_full > MAXV)
            scaled = {1'b0, {(OUT_W - 1){1'b1}}};
        else if (r_full < MINV)
            scaled = {1'b1, {(OUT_W - 1){1'b0}}};
    end
`else
    logic unused_r_high;
    assign unused_r_high = ^r_full[ACC_W:OUT_W];
    assign scaled        = r_full[OUT_W-1:0];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < NTAPS; i++) begin
                coef_q[i] <= '0;
                buf_q[i]  <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            k_q         <= '0;
            prod_q      <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            valid_out_q <= 1'b0;
            overrun_q   <= 1'b0;
            len_q       <= '0;
        end else begin
            state_q     <= state_d;
            valid_out_q <= (state_q == S_OUT);

            if (cfg_wr) begin
                for (int i = 0; i < NTAPS - 1; i++)
                    coef_q[i] <= coef_q[i+1];
                coef_q[NTAPS-1] <= bus.cfg_din;
                if (len_q != LEN_MAX)
                    len_q <= len_q + 1'b1;
            end

            if (accept) begin
                buf_q[wr_ptr_q] <= bus.in;
                wr_ptr_q        <= (wr_ptr_q == P_LAST) ? '0 : wr_ptr_q + 1'b1;
                rd_ptr_q        <= wr_ptr_q;
                k_q             <= '0;
                acc_q           <= '0;
            end

            if (state_q == S_MAC) begin
                prod_q   <= prod_d;
                rd_ptr_q <= (rd_ptr_q == '0) ? P_LAST : rd_ptr_q - 1'b1;
                k_q      <= k_q + 1'b1;
                // The first MAC cycle only fills the product register.
                if (k_q != '0)
                    acc_q <= acc_q + ACC_W'(prod_q);
            end

            if (state_q == S_DRAIN)
                acc_q <= acc_q + ACC_W'(prod_q);

            if (state_q == S_OUT)
                out_q <= scaled;

            if (drop)
                overrun_q <= 1'b1;
            else if (bus.clear_ovr)
                overrun_q <= 1'b0;
        end
    end

    assign bus.in_ready  = idle;
    assign bus.cfg_ready = idle;
    assign bus.out       = out_q;
    assign bus.valid_out = valid_out_q;
    assign bus.len       = len_q;
    assign bus.overrun   = overrun_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_param_fir_filter.sv
// Bench for param_fir_filter: a direct-convolution model queues each expected output when a sample is accepted.
// The negedge monitor pops and compares the queue on every valid_out.
module tb_param_fir_filter;
  localparam int IN_W      = 18;
  localparam int COEF_W    = 25;
  localparam int OUT_W     = 8;
  localparam int NTAPS     = 21;
  localparam int ACC_W     = 48;
  localparam int OUT_SHIFT = 29;
  localparam int LEN_W     = $clog2(NTAPS + 1);

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  param_fir_filter_if #(.IN_W(IN_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .NTAPS(NTAPS)) bus ();

  param_fir_filter #(
    .IN_W(IN_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .NTAPS(NTAPS),
    .ACC_W(ACC_W), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] mon_exp;
  int vectors = 0;
  int miscompares = 0;
  longint coef_m[NTAPS];
  longint hist_m[NTAPS];

  function automatic logic [OUT_W-1:0] model_out();
    longint acc = 0;
    longint r;
    for (int k = 0; k < NTAPS; k++) acc += coef_m[k] * hist_m[k];
    r = (acc + (longint'(1) <<< (OUT_SHIFT - 1))) >>> OUT_SHIFT;
`ifdef FIR_SAT_EN
    if (r > longint'((1 << (OUT_W - 1)) - 1)) r = longint'((1 << (OUT_W - 1)) - 1);
    if (r < -longint'(1 << (OUT_W - 1))) r = -longint'(1 << (OUT_W - 1));
`endif
    return r[OUT_W-1:0];
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < NTAPS; k++) begin
      coef_m[k] = 0;
      hist_m[k] = 0;
    end
    exp_q.delete();
  endfunction

  function automatic void model_cfg(input logic signed [COEF_W-1:0] w);
    for (int k = 0; k < NTAPS - 1; k++) coef_m[k] = coef_m[k+1];
    coef_m[NTAPS-1] = longint'(w);
  endfunction

  // Monitor: every valid_out must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset && bus.valid_out) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_valid_out: got out=%0d, none expected", bus.out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.out !== mon_exp) begin
          miscompares++;
          $display("FAIL out_value: got %0d want %0d", $signed(bus.out), $signed(mon_exp));
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: entered and left on a negedge.
  task automatic do_reset();
    reset = 1'b0;
    bus.in = '0;
    bus.valid_in = 1'b0;
    bus.cfg_din = '0;
    bus.cfg_ce = 1'b0;
    bus.clear_ovr = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic cfg_write(input logic signed [COEF_W-1:0] w);
    bus.cfg_din = w;
    bus.cfg_ce = 1'b1;
    model_cfg(w);
    @(negedge clk);
    bus.cfg_ce = 1'b0;
  endtask

  task automatic load_words(input int n, input int mode);
    logic signed [COEF_W-1:0] w;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0: w = COEF_W'($urandom_range(0, (1 << COEF_W) - 1));
        1: w = (i == 8) ? COEF_W'(1 << 19) : '0;
        2: w = (i == 0) ? COEF_W'(1 << 19) : '0;
        default: w = (i == 0) ? COEF_W'((1 << 24) - 1) : '0;
      endcase
      cfg_write(w);
    end
  endtask

  task automatic send_sample(input logic signed [IN_W-1:0] x, input bit expect_out,
                             input bit with_cfg, input logic signed [COEF_W-1:0] w);
    int t = 0;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL in_ready_timeout: got in_ready=0 want 1");
    end
    bus.in = x;
    bus.valid_in = 1'b1;
    if (with_cfg) begin
      bus.cfg_din = w;
      bus.cfg_ce = 1'b1;
      model_cfg(w);
    end
    if (expect_out) begin
      for (int k = NTAPS - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
      hist_m[0] = longint'(x);
      exp_q.push_back(model_out());
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.cfg_ce = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d outputs pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (bus.out !== '0) begin miscompares++; $display("FAIL reset_out: got %0d want 0", bus.out); end
    vectors++; if (bus.valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid_out: got %b want 0", bus.valid_out); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    vectors++; if (bus.cfg_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cfg_ready: got %b want 1", bus.cfg_ready); end
    vectors++; if (bus.len !== '0) begin miscompares++; $display("FAIL reset_len: got %0d want 0", bus.len); end
    vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
  endtask

  task automatic test_impulse();
    logic [LEN_W-1:0] exp_len = LEN_W'(NTAPS);
    int n;
    do_reset();
    load_words(NTAPS, 1);
    vectors++; if (bus.len !== exp_len) begin miscompares++; $display("FAIL impulse_len: got %0d want %0d", bus.len, exp_len); end
    for (int s = 0; s < 12; s++) begin
      send_sample(IN_W'(10240), 1'b1, 1'b0, '0);
      n = 1;
      while (!bus.valid_out && n < 40) begin
        @(negedge clk);
        n++;
      end
      vectors++; if (n != NTAPS + 3) begin miscompares++; $display("FAIL impulse_latency: got %0d want %0d", n, NTAPS + 3); end
      repeat (32 - n) @(negedge clk);
    end
    drain();
  endtask

  task automatic test_rounding();
    do_reset();
    load_words(NTAPS, 2);
    send_sample(IN_W'(511), 1'b1, 1'b0, '0);
    drain();
    send_sample(IN_W'(512), 1'b1, 1'b0, '0);
    drain();
    send_sample(-IN_W'(513), 1'b1, 1'b0, '0);
    drain();
  endtask

  task automatic test_saturation();
    do_reset();
    load_words(NTAPS, 3);
    send_sample(IN_W'(131071), 1'b1, 1'b0, '0);
    drain();
    send_sample(-IN_W'(131072), 1'b1, 1'b0, '0);
    drain();
  endtask

  task automatic test_overrun();
    do_reset();
    load_words(NTAPS, 0);
    send_sample(IN_W'($urandom_range(0, (1 << IN_W) - 1)), 1'b1, 1'b0, '0);
    repeat (4) @(negedge clk);
    bus.in = IN_W'($urandom_range(0, (1 << IN_W) - 1));
    bus.valid_in = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
    vectors++; if (bus.overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_set: got %b want 1", bus.overrun); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL overrun_in_ready: got %b want 0", bus.in_ready); end
    drain();
    repeat (10) @(negedge clk);
    bus.clear_ovr = 1'b1;
    @(negedge clk);
    bus.clear_ovr = 1'b0;
    vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL overrun_clear: got %b want 0", bus.overrun); end
    send_sample(IN_W'($urandom_range(0, (1 << IN_W) - 1)), 1'b1, 1'b0, '0);
    repeat (3) @(negedge clk);
    bus.valid_in = 1'b1;
    bus.clear_ovr = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.clear_ovr = 1'b0;
    vectors++; if (bus.overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_drop_wins: got %b want 1", bus.overrun); end
    drain();
    for (int i = 0; i < 3; i++) begin
      send_sample(IN_W'($urandom_range(0, (1 << IN_W) - 1)), 1'b1, 1'b0, '0);
      drain();
    end
  endtask

  task automatic test_cfg_gating();
    logic [LEN_W-1:0] exp_len;
    do_reset();
    load_words(10, 0);
    exp_len = LEN_W'(10);
    vectors++; if (bus.len !== exp_len) begin miscompares++; $display("FAIL gating_len_partial: got %0d want %0d", bus.len, exp_len); end
    send_sample(IN_W'($urandom_range(0, (1 << IN_W) - 1)), 1'b1, 1'b0, '0);
    repeat (2) @(negedge clk);
    vectors++; if (bus.cfg_ready !== 1'b0) begin miscompares++; $display("FAIL gating_cfg_ready: got %b want 0", bus.cfg_ready); end
    bus.cfg_din = COEF_W'($urandom_range(1, (1 << COEF_W) - 1));
    bus.cfg_ce = 1'b1;
    @(negedge clk);
    bus.cfg_ce = 1'b0;
    vectors++; if (bus.len !== exp_len) begin miscompares++; $display("FAIL gating_len_busy: got %0d want %0d", bus.len, exp_len); end
    drain();
    load_words(15, 0);
    exp_len = LEN_W'(NTAPS);
    vectors++; if (bus.len !== exp_len) begin miscompares++; $display("FAIL gating_len_sat: got %0d want %0d", bus.len, exp_len); end
    for (int i = 0; i < 3; i++) begin
      send_sample(IN_W'($urandom_range(0, (1 << IN_W) - 1)), 1'b1, 1'b0, '0);
      drain();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    load_words(NTAPS, 0);
    for (int i = 0; i < 8; i++)
      send_sample(IN_W'($urandom_range(0, (1 << IN_W) - 1)), 1'b1, (i == 4),
                  COEF_W'($urandom_range(0, (1 << COEF_W) - 1)));
    drain();
  endtask

  task automatic test_reset_mid_mac();
    do_reset();
    load_words(NTAPS, 2);
    send_sample(IN_W'(512), 1'b1, 1'b0, '0);
    drain();
    send_sample(IN_W'(1000), 1'b0, 1'b0, '0);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    vectors++; if (bus.out !== '0) begin miscompares++; $display("FAIL midreset_out: got %0d want 0", bus.out); end
    vectors++; if (bus.len !== '0) begin miscompares++; $display("FAIL midreset_len: got %0d want 0", bus.len); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_in_ready: got %b want 1", bus.in_ready); end
    reset = 1'b1;
    repeat (30) @(negedge clk);
    send_sample(IN_W'(5000), 1'b1, 1'b0, '0);
    drain();
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_impulse();
    test_rounding();
    test_saturation();
    test_overrun();
    test_cfg_gating();
    test_back_to_back();
    test_reset_mid_mac();
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
